prm_edge_mask_packer: RTL and testbench



---
 rtl/prm_mask_pkg.sv | 21 ++
 rtl/prm_popcnt.sv | 17 +
 rtl/prm_edge_mask_packer.sv | 122 ++++++++++++
 tb/tb_prm_edge_mask_packer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_mask_pkg.sv
// Shared types and sizing helpers for the PRM edge-mask packer.
package prm_mask_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEF_N_EDGES = 512;
  localparam int DEF_WORD_W  = 32;

  function automatic int n_words(input int n_edges, input int word_w);
    return (n_edges + word_w - 1) / word_w;
  endfunction

  // Index width never collapses to zero, even for single-word frames.
  function automatic int idx_w(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/prm_popcnt.sv
// Combinational population count of one output word.
module prm_popcnt #(
  parameter int WORD_W = 32,
  localparam int PC_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] i_data,
  output logic [PC_W-1:0]   o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      o_cnt = o_cnt + PC_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/prm_edge_mask_packer.sv
// Captures a full checker edge mask and streams it as WORD_W-wide words.
// Optional blocked-edge counter enabled by defining PRM_MASK_POPCNT_EN.
module prm_edge_mask_packer
  import prm_mask_pkg::*;
#(
  parameter int N_EDGES  = DEF_N_EDGES,
  parameter int WORD_W   = DEF_WORD_W,
  localparam int N_WORDS = n_words(N_EDGES, WORD_W),
  localparam int IDX_W   = idx_w(N_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mask_valid,
  input  logic [N_EDGES-1:0] mask_in,
  output logic               mask_ready,
  input  logic               abort,
  output logic               word_valid,
  output logic [WORD_W-1:0]  word_data,
  output logic [IDX_W-1:0]   word_idx,
  output logic               word_last,
  input  logic               word_ready
`ifdef PRM_MASK_POPCNT_EN
  ,
  output logic [$clog2(N_EDGES+1)-1:0] blocked_cnt,
  output logic                         cnt_valid
`endif
);

  localparam int PAD_W = N_WORDS * WORD_W;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [PAD_W-1:0]   r_mask;
  logic               w_capture;
  logic               w_hs;
  logic               w_last;

  assign w_last    = (r_idx == IDX_W'(N_WORDS - 1));
  assign w_capture = (r_state == IDLE) && mask_valid && !abort;
  assign w_hs      = (r_state == SEND) && word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_capture) w_state_nxt = SEND;
      SEND: if (abort || (word_ready && w_last)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The capture register shifts down one word per handshake, so the current
  // word always sits in the low bits; padding above N_EDGES is zero-filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_mask <= '0;
    end else if (w_capture) begin
      r_idx  <= '0;
      r_mask <= PAD_W'(mask_in);
    end else if (w_hs && !w_last) begin
      r_idx  <= r_idx + IDX_W'(1);
      r_mask <= r_mask >> WORD_W;
    end
  end

  assign mask_ready = (r_state == IDLE);
  assign word_valid = (r_state == SEND);
  assign word_data  = r_mask[WORD_W-1:0];
  assign word_idx   = r_idx;
  assign word_last  = w_last;

`ifdef PRM_MASK_POPCNT_EN
  localparam int CNT_W = $clog2(N_EDGES + 1);
  localparam int PC_W  = $clog2(WORD_W + 1);

  logic [PC_W-1:0]  w_pc;
  logic [CNT_W-1:0] w_acc_sum;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_blocked;
  logic             r_cnt_valid;

  prm_popcnt #(.WORD_W(WORD_W)) u_popcnt (
    .i_data (r_mask[WORD_W-1:0]),
    .o_cnt  (w_pc)
  );

  // Padding bits are zero, so the per-word count never exceeds N_EDGES in total.
  assign w_acc_sum = r_acc + CNT_W'(w_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_blocked   <= '0;
      r_cnt_valid <= 1'b0;
    end else begin
      r_cnt_valid <= 1'b0;
      if (w_capture) begin
        r_acc <= '0;
      end else if (w_hs) begin
        r_acc <= w_acc_sum;
      end
      if (w_hs && w_last && !abort) begin
        r_blocked   <= w_acc_sum;
        r_cnt_valid <= 1'b1;
      end
    end
  end

  assign blocked_cnt = r_blocked;
  assign cnt_valid   = r_cnt_valid;
`endif

endmodule

// File: tb/tb_prm_edge_mask_packer.sv
// Bench for prm_edge_mask_packer: directed scenarios plus randomized traffic
// against a frame-level reference model (40/16 and 16/16 instances).
module tb_prm_edge_mask_packer;

  localparam int NE = 40;
  localparam int WW = 16;
  localparam int NW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mask_valid = 1'b0;
  logic [NE-1:0] mask_in = '0;
  logic          abort = 1'b0;
  logic          word_ready = 1'b0;
  logic          mask_ready;
  logic          word_valid;
  logic [WW-1:0] word_data;
  logic [1:0]    word_idx;
  logic          word_last;

  logic          mv1 = 1'b0;
  logic [15:0]   mi1 = '0;
  logic          wr1 = 1'b0;
  logic          ab1 = 1'b0;
  logic          mr1;
  logic          vld1;
  logic [15:0]   data1;
  logic [0:0]    idx1;
  logic          last1;

`ifdef PRM_MASK_POPCNT_EN
  logic [5:0]    blocked_cnt;
  logic          cnt_valid;
  logic [4:0]    bc1;
  logic          cv1;
`endif

  always #5 clk = ~clk;

  prm_edge_mask_packer #(.N_EDGES(NE), .WORD_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_valid (mask_valid),
    .mask_in    (mask_in),
    .mask_ready (mask_ready),
    .abort      (abort),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .word_ready (word_ready)
`ifdef PRM_MASK_POPCNT_EN
    ,
    .blocked_cnt(blocked_cnt),
    .cnt_valid  (cnt_valid)
`endif
  );

  prm_edge_mask_packer #(.N_EDGES(16), .WORD_W(16)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_valid (mv1),
    .mask_in    (mi1),
    .mask_ready (mr1),
    .abort      (ab1),
    .word_valid (vld1),
    .word_data  (data1),
    .word_idx   (idx1),
    .word_last  (last1),
    .word_ready (wr1)
`ifdef PRM_MASK_POPCNT_EN
    ,
    .blocked_cnt(bc1),
    .cnt_valid  (cv1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model.
  bit            m_busy;
  int            m_idx;
  logic [NE-1:0] m_mask;
  int            exp_bc;
  bit            exp_cv;
  logic [WW-1:0] hs_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_idx  = 0;
    m_mask = '0;
    exp_bc = 0;
    exp_cv = 0;
  endtask

  task automatic model_update(input logic mv, input logic [NE-1:0] mi, input logic wr, input logic ab);
    exp_cv = 0;
    if (m_busy) begin
      if (wr) begin
        if (m_idx == NW - 1) begin
          if (!ab) begin
            exp_bc = $countones(m_mask);
            exp_cv = 1;
          end
          m_busy = 0;
        end else begin
          m_idx++;
        end
      end
      if (ab) m_busy = 0;
    end else if (mv && !ab) begin
      m_busy = 1;
      m_mask = mi;
      m_idx  = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NE-1:0] sh;
    check("mask_ready", mask_ready, !m_busy);
    check("word_valid", word_valid, m_busy);
    if (m_busy) begin
      sh = m_mask >> (WW * m_idx);
      check("word_data", word_data, sh[WW-1:0]);
      check("word_idx", word_idx, m_idx);
      check("word_last", word_last, m_idx == NW - 1);
    end
`ifdef PRM_MASK_POPCNT_EN
    check("blocked_cnt", blocked_cnt, exp_bc);
    check("cnt_valid", cnt_valid, exp_cv);
`endif
  endtask

  // Called just after a rising edge: applies inputs for the next edge.
  task automatic step(input logic mv, input logic [NE-1:0] mi, input logic wr, input logic ab);
    mask_valid = mv;
    mask_in    = mi;
    word_ready = wr;
    abort      = ab;
    if (word_valid && wr) hs_log.push_back(word_data);
    model_update(mv, mi, wr, ab);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_frame(input logic [NE-1:0] mi);
    step(1'b1, mi, 1'b0, 1'b0);
    for (int k = 0; k < NW; k++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  localparam logic [NE-1:0] FR_A = 40'hA5_1234_FFFF;
  localparam logic [NE-1:0] FR_P = 40'hFF_0000_0001;

  initial begin
    logic [63:0] rnd;
    logic [31:0] r32;
    logic        rwr;
    bit          p1_busy;
    logic [15:0] p1_word;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst mask_ready", mask_ready, 1'b1);
    check("rst word_valid", word_valid, 1'b0);
    rst_n = 1'b1;
    check_outputs();

    // Full frame with constant ready.
    hs_log.delete();
    step(1'b1, FR_A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("mask_ready before last", mask_ready, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("mask_ready T+4", mask_ready, 1'b1);
    check("hs count A", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("word0 A", hs_log[0], 16'hFFFF);
      check("word1 A", hs_log[1], 16'h1234);
      check("word2 A", hs_log[2], 16'h00A5);
    end

    // Stalled delivery.
    hs_log.delete();
    step(1'b1, FR_A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("hs count stall", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("word0 stall", hs_log[0], 16'hFFFF);
      check("word1 stall", hs_log[1], 16'h1234);
      check("word2 stall", hs_log[2], 16'h00A5);
    end

    // Abort together with the idx-1 handshake.
    hs_log.delete();
    step(1'b1, FR_A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    check("abort idle valid", word_valid, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("abort hs count", hs_log.size(), 2);
    step(1'b1, FR_P, 1'b0, 1'b0);
    check("restart idx", word_idx, 0);

    // Abort in IDLE blocks capture.
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, FR_A, 1'b1, 1'b1);
    check("abort idle no capture", word_valid, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Popcount frames.
    send_frame(FR_P);
`ifdef PRM_MASK_POPCNT_EN
    check("popcnt 9", blocked_cnt, 9);
    check("popcnt pulse", cnt_valid, 1'b1);
`endif
    step(1'b0, '0, 1'b0, 1'b0);
    send_frame('0);
`ifdef PRM_MASK_POPCNT_EN
    check("popcnt 0", blocked_cnt, 0);
`endif
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset during idx 1 of a frame after a nonzero count.
    send_frame(FR_P);
    step(1'b1, FR_A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre-reset idx", word_idx, 1);
    mask_valid = 1'b0;
    word_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset valid", word_valid, 1'b0);
`ifdef PRM_MASK_POPCNT_EN
    check("reset blocked_cnt", blocked_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_outputs();
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      rnd = {$urandom(), $urandom()};
      r32 = $urandom();
      rwr = (r32[1:0] != 2'b00);
      step(r32[2], rnd[NE-1:0], rwr, r32[7:4] == 4'h0);
    end

    // Single-word frames, back-to-back, on the 16/16 instance.
    step(1'b0, '0, 1'b0, 1'b0);
    mv1 = 1'b1;
    wr1 = 1'b1;
    p1_busy = 0;
    p1_word = '0;
    for (int k = 0; k < 10; k++) begin
      r32 = $urandom();
      mi1 = r32[15:0];
      if (p1_busy) begin
        p1_busy = 0;
      end else begin
        p1_busy = 1;
        p1_word = mi1;
      end
      @(posedge clk);
      #1;
      check("sw valid", vld1, p1_busy);
      check("sw mask_ready", mr1, !p1_busy);
      check("sw last", last1, 1'b1);
      if (p1_busy) check("sw data", data1, p1_word);
    end
    mv1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
